chunked_add_sub: RTL



---
 rtl/chunked_add_sub_if.sv | 26 ++
 rtl/chunked_add_sub.sv | 99 +++++++++
 2 files changed

// File: rtl/chunked_add_sub_if.sv
// Operation request / result bundle for the chunked adder-subtractor.
// The controller drives start/sub/a/b; the arithmetic unit returns status and result.
interface chunked_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered carry.
// Result and flags are loaded into output registers only on the final chunk.
module chunked_add_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input logic              clk,
    input logic              reset,
    chunked_add_sub_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     sum_q;
    logic                 carry;
    logic                 cout_q;
    logic                 ovf_q;
    logic                 zero_q;
    logic [CW-1:0]        cnt;
    logic [CHUNK:0]       csum;
    logic                 cin_msb;
    logic [WIDTH+CHUNK-1:0] acc_ext;
    logic [WIDTH-1:0]     acc_nx;
    logic                 last;
    logic                 accept;

    always_comb begin
        csum    = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        // Carry into the chunk's top bit recovered from its sum bit and operands.
        cin_msb = csum[CHUNK-1] ^ opa[CHUNK-1] ^ opb[CHUNK-1];
        acc_ext = {csum[CHUNK-1:0], acc};
        acc_nx  = acc_ext[WIDTH+CHUNK-1:CHUNK];
        last    = (cnt == CW'(N - 1));
        accept  = (state != RUN) && bus.start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> CHUNK;
            opb   <= opb >> CHUNK;
            acc   <= acc_nx;
            carry <= csum[CHUNK];
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum_q  <= acc_nx;
                cout_q <= csum[CHUNK];
                ovf_q  <= cin_msb ^ csum[CHUNK];
                zero_q <= (acc_nx == '0);
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule
